// File: rtl/float_to_iq_stream_pkg.sv
// -----------------------------------------------------------------------------
// float_to_iq_stream_pkg
// Purpose : IEEE-754 single-precision field constants shared by the float to
//           fixed-point I/Q stream converter and its per-component lanes.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package float_to_iq_stream_pkg;

    localparam int FP_EXP_W   = 8;    // exponent field width
    localparam int FP_MAN_W   = 23;   // stored mantissa width (hidden bit excluded)
    localparam int FP_BIAS    = 127;  // exponent bias
    localparam int FP_EXP_INF = 255;  // exponent code for Inf/NaN

endpackage

// File: rtl/float_to_fixed_lane.sv
// -----------------------------------------------------------------------------
// float_to_fixed_lane
// Purpose : Converts one float32 component to a WIDTH-bit two's-complement
//           value scaled by 2^(WIDTH-1) * 2^scale_exp. Round to nearest, ties
//           away from zero, symmetric clamp to +/-(2^(WIDTH-1)-1).
//           Three register stages, all advanced by en:
//             S1 field decode + effective shift, S2 barrel shift + guard bit,
//             S3 round, saturate, negate.
// Ports   : clk, reset (sync, active-high; clears the output register only)
//           en         - pipeline advance enable
//           fp         - float32 input
//           scale_exp  - signed power-of-two gain, used in S1
//           val        - signed fixed-point result (S3 register)
//           sat        - result was clamped (S3 register)
// -----------------------------------------------------------------------------
module float_to_fixed_lane
    import float_to_iq_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [31:0]             fp,
    input  logic signed [7:0]       scale_exp,
    output logic signed [WIDTH-1:0] val,
    output logic                    sat
);

    localparam int MAN_FULL_W = FP_MAN_W + 1;
    // Value in output LSBs is M * 2^sh with M the 24-bit significand and
    // sh = exp - bias - 23 + (WIDTH-1) + scale_exp.
    localparam logic signed [10:0] SH_OFS = 11'(WIDTH - 1 - FP_BIAS - FP_MAN_W);
    localparam logic [MAN_FULL_W-1:0] MAX_MAG = MAN_FULL_W'((1 << (WIDTH - 1)) - 1);

    // Round half away from zero on the magnitude, clamp, then apply sign.
    // Returns {sat, value}.
    function automatic logic [WIDTH:0] round_sat(
        input logic                  sign,
        input logic [MAN_FULL_W-2:0] mag,
        input logic                  guard,
        input logic                  ovf
    );
        logic [MAN_FULL_W-1:0] rnd;
        logic                  s;
        logic [WIDTH-1:0]      m;
        logic [WIDTH-1:0]      v;
        rnd = {1'b0, mag} + MAN_FULL_W'(guard);
        s   = ovf || (rnd > MAX_MAG);
        m   = s ? MAX_MAG[WIDTH-1:0] : rnd[WIDTH-1:0];
        v   = sign ? (~m + 1'b1) : m;
        return {s, v};
    endfunction

    // ---------------- S1: field decode and effective exponent ----------------
    logic [FP_EXP_W-1:0]   exp_f;
    logic [FP_MAN_W-1:0]   man_f;
    logic signed [10:0]    sh_c;
    logic                  is_special;

    assign exp_f      = fp[30:23];
    assign man_f      = fp[22:0];
    assign is_special = (exp_f == FP_EXP_W'(FP_EXP_INF));
    assign sh_c       = $signed({3'b000, exp_f}) + $signed({{3{scale_exp[7]}}, scale_exp}) + SH_OFS;

    logic                  sign_p0;
    logic [MAN_FULL_W-1:0] man_p0;
    logic signed [10:0]    sh_p0;
    logic                  zero_p0;   // zero, denormal or NaN: forces 0
    logic                  inf_p0;

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p0 <= fp[31];
            man_p0  <= {1'b1, man_f};
            sh_p0   <= sh_c;
            zero_p0 <= (exp_f == '0) || (is_special && (man_f != '0));
            inf_p0  <= is_special && (man_f == '0);
        end
    end

    // ---------------- S2: barrel shift with guard bit ----------------
    // One bit less than the full right shift is applied so the LSB of the
    // shifted significand is the guard (half-LSB) bit. Any non-negative sh
    // gives at least 2^23 LSBs, which exceeds the clamp for every WIDTH.
    logic [10:0]           rsh_c;
    logic [MAN_FULL_W-1:0] shifted_c;
    logic                  ovf_c;

    assign rsh_c     = $unsigned(-sh_p0 - 11'sd1);
    assign shifted_c = (rsh_c >= 11'd24) ? '0 : (man_p0 >> rsh_c[4:0]);
    assign ovf_c     = inf_p0 || (!zero_p0 && !sh_p0[10]);

    logic                  sign_p1;
    logic [MAN_FULL_W-2:0] mag_p1;
    logic                  guard_p1;
    logic                  ovf_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1  <= sign_p0;
            mag_p1   <= zero_p0 ? '0 : shifted_c[MAN_FULL_W-1:1];
            guard_p1 <= zero_p0 ? 1'b0 : shifted_c[0];
            ovf_p1   <= ovf_c;
        end
    end

    // ---------------- S3: round, saturate, negate ----------------
    logic [WIDTH:0] res_c;
    assign res_c = round_sat(sign_p1, mag_p1, guard_p1, ovf_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            val <= '0;
            sat <= 1'b0;
        end else if (en) begin
            val <= $signed(res_c[WIDTH-1:0]);
            sat <= res_c[WIDTH];
        end
    end

endmodule

// File: rtl/float_to_iq_stream.sv
// -----------------------------------------------------------------------------
// float_to_iq_stream
// Purpose : AXI-stream converter from packed float32 I/Q pairs to packed
//           WIDTH-bit two's-complement I/Q, with a runtime power-of-two gain
//           and a saturating count of clamped output samples.
// Ports   : clk, reset (sync, active-high)
//           i_tdata {I[63:32], Q[31:0]} float32, i_tvalid, i_tlast, i_tready
//           o_tdata {I, Q} fixed point, o_tvalid, o_tlast, o_tready
//           scale_exp   - signed gain exponent, sampled with the input
//           clear_stats - synchronous clear of sat_count (wins over increment)
//           sat_count   - output handshakes with I or Q saturated, sticks at max
// -----------------------------------------------------------------------------
module float_to_iq_stream
    import float_to_iq_stream_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SAT_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            i_tdata,
    input  logic                   i_tvalid,
    input  logic                   i_tlast,
    output logic                   i_tready,
    output logic [2*WIDTH-1:0]     o_tdata,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    input  logic                   o_tready,
    input  logic signed [7:0]      scale_exp,
    input  logic                   clear_stats,
    output logic [SAT_CNT_W-1:0]   sat_count
);

    // A single enable moves the whole pipeline; it is high whenever the
    // output register is empty or being consumed, so bubbles collapse.
    logic en;
    assign en       = o_tready | ~o_tvalid;
    assign i_tready = en;

    logic signed [WIDTH-1:0] val_i, val_q;
    logic                    sat_i, sat_q;

    float_to_fixed_lane #(.WIDTH(WIDTH)) u_lane_i (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fp        (i_tdata[63:32]),
        .scale_exp (scale_exp),
        .val       (val_i),
        .sat       (sat_i)
    );

    float_to_fixed_lane #(.WIDTH(WIDTH)) u_lane_q (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fp        (i_tdata[31:0]),
        .scale_exp (scale_exp),
        .val       (val_q),
        .sat       (sat_q)
    );

    assign o_tdata = {val_i, val_q};

    // ---------------- valid / last pipeline (S1, S2, S3) ----------------
    logic vld_p0, vld_p1;
    logic last_p0, last_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            o_tvalid <= 1'b0;
            last_p0  <= 1'b0;
            last_p1  <= 1'b0;
            o_tlast  <= 1'b0;
        end else if (en) begin
            vld_p0   <= i_tvalid;
            vld_p1   <= vld_p0;
            o_tvalid <= vld_p1;
            last_p0  <= i_tvalid & i_tlast;
            last_p1  <= last_p0;
            o_tlast  <= last_p1;
        end
    end

    // ---------------- saturation statistics ----------------
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            sat_count <= '0;
        end else if (o_tvalid && o_tready && (sat_i || sat_q) && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule
